// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_arbiter
// Purpose  : Shares the single instruction-memory port between the IFU fetch
//            path (port 0) and a secondary read-only requester (port 1).
//            Round-robin grant with a zero-cycle combinational accept; an
//            outstanding-request source FIFO routes in-order responses back
//            to the issuing port. Port-0 requests in flight at a redirect
//            (r0_flush) are marked killed and their responses are dropped.
// Ports    : clk, rstn (synchronous, active-low)
//            r0_* : IFU request (addr/tag/valid/ready/flush) and response
//                   (rdata/rdata_valid/tag_out)
//            r1_* : secondary requester, same as port 0 without flush
//            mem_*: memory request (addr/addr_valid/tag_out) and in-order
//                   response (rdata/rdata_valid/tag_in)
//            err_orphan_rsp : sticky, response seen with nothing outstanding
// Revision : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int TAG_WIDTH       = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [TAG_WIDTH-1:0]  r0_tag,
    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic                  r0_flush,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    output logic                  r0_rdata_valid,
    output logic [TAG_WIDTH-1:0]  r0_tag_out,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [TAG_WIDTH-1:0]  r1_tag,
    input  logic                  r1_valid,
    output logic                  r1_ready,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  r1_rdata_valid,
    output logic [TAG_WIDTH-1:0]  r1_tag_out,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_addr_valid,
    output logic [TAG_WIDTH-1:0]  mem_tag_out,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rdata_valid,
    input  logic [TAG_WIDTH-1:0]  mem_tag_in,
    output logic                  err_orphan_rsp
);

    localparam int c_ptr_w = $clog2(MAX_OUTSTANDING);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(MAX_OUTSTANDING);

    // Source FIFO: one {src, kill} pair per outstanding request.
    logic [MAX_OUTSTANDING-1:0] r_src;
    logic [MAX_OUTSTANDING-1:0] r_kill;
    logic [c_ptr_w-1:0]         r_wptr;
    logic [c_ptr_w-1:0]         r_rptr;
    logic [c_cnt_w-1:0]         r_count;
    logic                       r_last_gnt;
    logic                       r_err;

    logic                       w_issue_ok;
    logic                       w_req0;
    logic                       w_gnt0;
    logic                       w_gnt1;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_head_src;
    logic                       w_head_kill;
    logic [MAX_OUTSTANDING-1:0] w_live;
    logic [MAX_OUTSTANDING-1:0] w_kill_nxt;

    // A full FIFO may still issue when the head is retired in the same cycle.
    assign w_issue_ok = (r_count < c_max_cnt) | ((r_count == c_max_cnt) & mem_rdata_valid);

    // A redirect masks the IFU request for that cycle.
    assign w_req0 = r0_valid & ~r0_flush;

    // Tie goes to the port that did not win last time.
    assign w_gnt0 = w_issue_ok & w_req0   & (~r1_valid | r_last_gnt);
    assign w_gnt1 = w_issue_ok & r1_valid & (~w_req0   | ~r_last_gnt);
    assign w_push = w_gnt0 | w_gnt1;

    assign r0_ready       = w_gnt0;
    assign r1_ready       = w_gnt1;
    assign mem_addr_valid = w_push;
    assign mem_addr       = w_gnt1 ? r1_addr : r0_addr;
    assign mem_tag_out    = w_gnt1 ? r1_tag  : r0_tag;

    // A response with nothing outstanding is an orphan and is not popped.
    assign w_pop       = mem_rdata_valid & (r_count != '0);
    assign w_head_src  = r_src[r_rptr];
    assign w_head_kill = r_kill[r_rptr];

    assign r0_rdata_valid = w_pop & ~w_head_src & ~w_head_kill & ~r0_flush;
    assign r1_rdata_valid = w_pop &  w_head_src & ~w_head_kill;
    assign r0_rdata       = mem_rdata;
    assign r1_rdata       = mem_rdata;
    assign r0_tag_out     = mem_tag_in;
    assign r1_tag_out     = mem_tag_in;
    assign err_orphan_rsp = r_err;

    // An entry is live when its distance from the read pointer (mod depth)
    // is below the occupancy count.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_live
            logic [c_ptr_w-1:0] w_dist;
            assign w_dist     = c_ptr_w'(gi) - r_rptr;
            assign w_live[gi] = {1'b0, w_dist} < r_count;
        end
    endgenerate

    // Flush kills every live port-0 entry, the head being popped included.
    // A push never carries a killed entry; in a flush cycle it can only be
    // a port-1 push, so the fresh slot overriding a kill is harmless.
    always_comb begin
        w_kill_nxt = r_kill;
        if (r0_flush) begin
            w_kill_nxt = r_kill | (w_live & ~r_src);
        end
        if (w_push) begin
            w_kill_nxt[r_wptr] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_src      <= '0;
            r_kill     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_last_gnt <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            r_kill <= w_kill_nxt;
            if (w_push) begin
                r_src[r_wptr] <= w_gnt1;
                r_wptr        <= r_wptr + c_ptr_w'(1);
                r_last_gnt    <= w_gnt1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_w'(1);
            end
            if (mem_rdata_valid && (r_count == '0)) begin
                r_err <= 1'b1;
            end
            r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_arbiter
// Purpose  : Directed self-checking bench for imem_arbiter. A small memory
//            model answers each issued request in order after a selectable
//            latency; expected grants, routing and tags are hand-computed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] r0_addr = '0, r1_addr = '0;
    logic [31:0] r0_tag = '0, r1_tag = '0;
    logic        r0_valid = 1'b0, r1_valid = 1'b0, r0_flush = 1'b0;
    logic        r0_ready, r1_ready;
    logic [31:0] r0_rdata, r1_rdata, r0_tag_out, r1_tag_out;
    logic        r0_rdata_valid, r1_rdata_valid;
    logic [31:0] mem_addr, mem_tag_out;
    logic        mem_addr_valid;
    logic [31:0] mem_rdata = '0, mem_tag_in = '0;
    logic        mem_rdata_valid = 1'b0;
    logic        err_orphan_rsp;

    imem_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TAG_WIDTH(32), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .rstn(rstn),
        .r0_addr(r0_addr), .r0_tag(r0_tag), .r0_valid(r0_valid), .r0_ready(r0_ready),
        .r0_flush(r0_flush), .r0_rdata(r0_rdata), .r0_rdata_valid(r0_rdata_valid),
        .r0_tag_out(r0_tag_out),
        .r1_addr(r1_addr), .r1_tag(r1_tag), .r1_valid(r1_valid), .r1_ready(r1_ready),
        .r1_rdata(r1_rdata), .r1_rdata_valid(r1_rdata_valid), .r1_tag_out(r1_tag_out),
        .mem_addr(mem_addr), .mem_addr_valid(mem_addr_valid), .mem_tag_out(mem_tag_out),
        .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid), .mem_tag_in(mem_tag_in),
        .err_orphan_rsp(err_orphan_rsp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] tag;
        int          due;
    } req_t;

    req_t mq[$];
    int   cyc = 0;
    int   lat = 2;
    logic force_rsp = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Values sampled mid-cycle by tick()
    logic        s_r0_ready, s_r1_ready, s_mav, s_r0v, s_r1v, s_err;
    logic [31:0] s_mtag, s_r0tag, s_r1tag, s_r0data, s_r1data;

    function automatic logic [31:0] rdata_of(input logic [31:0] tag);
        return tag ^ 32'hCAFE_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: present the memory response, sample outputs, record
    // any issued request, then advance to just after the next rising edge.
    task automatic tick();
        if (force_rsp) begin
            mem_rdata_valid = 1'b1;
            mem_tag_in      = 32'h0000_DEAD;
            mem_rdata       = rdata_of(32'h0000_DEAD);
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            mem_rdata_valid = 1'b1;
            mem_tag_in      = mq[0].tag;
            mem_rdata       = rdata_of(mq[0].tag);
        end else begin
            mem_rdata_valid = 1'b0;
        end
        #2;
        s_r0_ready = r0_ready;  s_r1_ready = r1_ready;  s_mav = mem_addr_valid;
        s_mtag     = mem_tag_out;
        s_r0v      = r0_rdata_valid; s_r0tag = r0_tag_out; s_r0data = r0_rdata;
        s_r1v      = r1_rdata_valid; s_r1tag = r1_tag_out; s_r1data = r1_rdata;
        s_err      = err_orphan_rsp;
        if (mem_addr_valid) mq.push_back('{tag: mem_tag_out, due: cyc + lat});
        if (mem_rdata_valid && !force_rsp) void'(mq.pop_front());
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        r0_valid = 1'b0; r1_valid = 1'b0; r0_flush = 1'b0; force_rsp = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        mq.delete();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic drain();
        idle_inputs();
        for (int i = 0; i < 40 && mq.size() > 0; i++) tick();
        check("drain_timeout", 64'(mq.size()), 64'd0);
    endtask

    initial begin
        @(posedge clk);
        #1;

        // ---------------- reset state ----------------
        do_reset();
        tick();
        check("rst_count", 64'(dut.r_count), 64'd0);
        check("rst_err", s_err, 1'b0);
        check("rst_mav", s_mav, 1'b0);
        check("rst_r0_ready", s_r0_ready, 1'b0);

        // ---------------- port 0 only, latency 2 ----------------
        lat = 2;
        for (int k = 0; k < 8; k++) begin
            r0_valid = 1'b1; r0_tag = 32'h40 + 32'(k); r0_addr = 32'(k * 4);
            tick();
            check("p0_ready", s_r0_ready, 1'b1);
            check("p0_r1v", s_r1v, 1'b0);
            check("p0_r0v", s_r0v, (k >= 2));
            if (k >= 2) begin
                check("p0_tag", s_r0tag, 32'h40 + 32'(k - 2));
                check("p0_data", s_r0data, rdata_of(32'h40 + 32'(k - 2)));
            end
        end
        check("p0_count", 64'(dut.r_count), 64'd2);
        drain();

        // ---------------- both valid, alternation ----------------
        do_reset();
        lat = 2;
        for (int k = 0; k < 8; k++) begin
            r0_valid = 1'b1; r1_valid = 1'b1;
            r0_tag = 32'h10 + 32'(k / 2); r1_tag = 32'h20 + 32'(k / 2);
            tick();
            check("alt_r0_ready", s_r0_ready, (k % 2 == 0));
            check("alt_r1_ready", s_r1_ready, (k % 2 == 1));
            check("alt_mtag", s_mtag, (k % 2 == 0) ? 32'h10 + 32'(k / 2) : 32'h20 + 32'(k / 2));
            check("alt_r0v", s_r0v, (k >= 2) && (k % 2 == 0));
            check("alt_r1v", s_r1v, (k >= 2) && (k % 2 == 1));
            if (k >= 2 && k % 2 == 0) check("alt_r0tag", s_r0tag, 32'h10 + 32'((k - 2) / 2));
            if (k >= 2 && k % 2 == 1) begin
                check("alt_r1tag", s_r1tag, 32'h20 + 32'((k - 2) / 2));
                check("alt_r1data", s_r1data, rdata_of(32'h20 + 32'((k - 2) / 2)));
            end
        end
        drain();

        // ---------------- latency 10, full FIFO ----------------
        do_reset();
        lat = 10;
        for (int k = 0; k < 12; k++) begin
            r0_valid = 1'b1; r0_tag = 32'h300 + 32'(k);
            tick();
            check("full_ready", s_r0_ready, (k < 4) || (k >= 10));
            check("full_r0v", s_r0v, (k >= 10));
            if (k >= 10) check("full_tag", s_r0tag, 32'h300 + 32'(k - 10));
        end
        check("full_count", 64'(dut.r_count), 64'd4);
        drain();

        // ---------------- flush kills in-flight port-0 responses ----------------
        do_reset();
        lat = 5;
        for (int k = 0; k <= 10; k++) begin
            idle_inputs();
            if (k <= 2) begin r0_valid = 1'b1; r0_tag = 32'h100 + 32'(4 * k); end
            if (k == 3) begin r1_valid = 1'b1; r1_tag = 32'h500; end
            if (k == 4 || k == 5) begin r0_valid = 1'b1; r0_tag = 32'h200; end
            if (k == 4) r0_flush = 1'b1;
            tick();
            if (k == 4) begin
                check("fl_ready_in_flush", s_r0_ready, 1'b0);
                check("fl_mav_in_flush", s_mav, 1'b0);
            end
            if (k == 5) check("fl_ready_after", s_r0_ready, 1'b1);
            check("fl_r0v", s_r0v, (k == 10));
            check("fl_r1v", s_r1v, (k == 8));
            if (k == 8)  check("fl_r1tag", s_r1tag, 32'h500);
            if (k == 10) check("fl_r0tag", s_r0tag, 32'h200);
        end
        drain();

        // Flush in the very cycle the head response returns
        lat = 2;
        r0_valid = 1'b1; r0_tag = 32'h600;
        tick();
        check("fh_ready", s_r0_ready, 1'b1);
        idle_inputs();
        tick();
        r0_flush = 1'b1;
        tick();
        check("fh_r0v", s_r0v, 1'b0);
        r0_flush = 1'b0;
        tick();
        check("fh_count", 64'(dut.r_count), 64'd0);
        check("fh_err", s_err, 1'b0);

        // ---------------- orphan response ----------------
        do_reset();
        force_rsp = 1'b1;
        tick();
        check("orph_r0v", s_r0v, 1'b0);
        check("orph_r1v", s_r1v, 1'b0);
        check("orph_err_same", s_err, 1'b0);
        force_rsp = 1'b0;
        tick();
        check("orph_err_next", s_err, 1'b1);
        lat = 2;
        r1_valid = 1'b1; r1_tag = 32'h77;
        tick();
        drain();
        tick();
        check("orph_err_sticky", s_err, 1'b1);
        do_reset();
        tick();
        check("orph_err_cleared", s_err, 1'b0);

        // ---------------- reset mid-operation ----------------
        lat = 10;
        idle_inputs(); r1_valid = 1'b1; r1_tag = 32'h900; tick();
        r1_tag = 32'h901; tick();
        idle_inputs(); r0_valid = 1'b1; r0_tag = 32'h800; tick();
        check("mid_count_before", 64'(dut.r_count), 64'd3);
        do_reset();
        check("mid_count_after", 64'(dut.r_count), 64'd0);
        r0_valid = 1'b1; r1_valid = 1'b1; r0_tag = 32'hA0; r1_tag = 32'hB0;
        tick();
        check("mid_tie_r0", s_r0_ready, 1'b1);
        check("mid_tie_r1", s_r1_ready, 1'b0);
        check("mid_tie_tag", s_mtag, 32'hA0);
        tick();
        check("mid_next_r1", s_r1_ready, 1'b1);
        drain();
        check("mid_err", s_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single instruction-memory port between two requesters.
- Port 0 is IFU fetch; port 1 is a secondary requester (LSU load of read-only data from instruction memory, or the debug module).
- Round-robin grant, with in-order response routing through an outstanding-request source FIFO.
- Port-0 responses still in flight when a pipeline redirect (flush) occurs are discarded.
- Sits between ifu/secondary requester and the instruction memory.

Parameters:
- ADDR_WIDTH, INSTR_MEM_ADDR_WIDTH, request address width.
- DATA_WIDTH, INSTR_MEM_WIDTH, read-data width.
- TAG_WIDTH, XLEN, request/response tag width (passed through memory untouched).
- MAX_OUTSTANDING, 4, maximum issued-but-unanswered requests; power of 2, >= 2.

Ports:
- clk  input  1  clock
- rstn  input  1  reset; synchronous, active-low
- r0_addr  input  ADDR_WIDTH  port-0 (IFU) request address
- r0_tag  input  TAG_WIDTH  port-0 request tag
- r0_valid  input  1  port-0 request valid
- r0_ready  output  1  port-0 request accepted this cycle
- r0_flush  input  1  port-0 redirect (pc_load): kill all in-flight port-0 requests
- r0_rdata  output  DATA_WIDTH  port-0 response data
- r0_rdata_valid  output  1  port-0 response valid
- r0_tag_out  output  TAG_WIDTH  port-0 response tag
- r1_addr, r1_tag, r1_valid, r1_ready, r1_rdata, r1_rdata_valid, r1_tag_out  same as port 0 (port 1 has no flush)
- mem_addr  output  ADDR_WIDTH  memory address
- mem_addr_valid  output  1  memory request strobe
- mem_tag_out  output  TAG_WIDTH  tag sent with the request
- mem_rdata  input  DATA_WIDTH  memory read data
- mem_rdata_valid  input  1  memory response valid (in order, at least 1 cycle after request)
- mem_tag_in  input  TAG_WIDTH  tag returned with the response
- err_orphan_rsp  output  1  sticky: response arrived with the FIFO empty

Behaviour:
- Issue is permitted when count < MAX_OUTSTANDING, or when count == MAX_OUTSTANDING and mem_rdata_valid=1 this cycle.
- Grant, when issue is permitted:
  - Only one port valid: that port wins.
  - Both valid: the port not granted last time (last_gnt register) wins.
- r0_flush=1 masks r0_valid for that cycle; no port-0 grant is made in a flush cycle.
- Issue is not permitted: r0_ready=r1_ready=0, mem_addr_valid=0.
- Grant path is combinational: mem_addr_valid = r0_ready | r1_ready, and mem_addr/mem_tag_out are muxed from the winner. A winner's ready is asserted in the same cycle as its valid (zero-cycle accept).
- On a grant, last_gnt <= winner.
- Source FIFO: MAX_OUTSTANDING entries, each {src, kill}.
  - Push {winner, 0} on each grant.
  - Pop head on each mem_rdata_valid.
  - Push and pop in the same cycle leave count unchanged. count width is clog2(MAX_OUTSTANDING)+1, with pointers wrapping modulo MAX_OUTSTANDING.
- Flush: r0_flush=1 sets kill=1, at the clock edge, on every valid entry with src=0, including the head being popped that cycle.
  - The head response in a flush cycle is also suppressed combinationally.
  - The net effect: no port-0 response whose request was issued before the flush cycle is ever delivered.
- Response routing is combinational from the FIFO head, with zero added latency:
  - rN_rdata_valid = mem_rdata_valid & head.src==N & ~head.kill, and for port 0 also & ~r0_flush.
  - rN_rdata = mem_rdata and rN_tag_out = mem_tag_in on both ports at all times; validity is the only qualifier.
- Killed responses are popped and dropped silently.
- mem_rdata_valid with count==0: no pop, no delivery, err_orphan_rsp <= 1; it stays set until reset.
- Reset (also mid-operation):
  - count=0, pointers=0, all kill bits=0, last_gnt=1 (so port 0 wins the first tie), err_orphan_rsp=0.
  - Combinational outputs follow from these values, so all ready/valid outputs read 0 unless a valid input is present.
  - Responses returning after reset count as orphans.

Test Plan:
- Port 0 only, valid every cycle, 2-cycle memory latency: steady state 1 grant/cycle, count holds at 2, each r0_rdata_valid carries the matching tag, and r1 never asserts valid.
- Both valid continuously: grants alternate 0,1,0,1 starting with port 0 after reset; responses route to the issuing port in order with tags intact.
- Memory latency 10 with MAX_OUTSTANDING=4: after 4 grants ready=0 until the first response. In the cycle of that response, a new grant issues and count stays 4.
- Issue r0 tags 0x100, 0x104, 0x108, then assert r0_flush one cycle before the 0x100 response and issue 0x200 after: no response for 0x100/0x104/0x108 is delivered, 0x200 is delivered, and an interleaved r1 response is unaffected.
- Drive mem_rdata_valid with no request outstanding: err_orphan_rsp=1 the next cycle, no rN_rdata_valid, and the flag stays set until rstn=0.
- Assert rstn=0 with 3 requests outstanding: the next cycle count=0, ready=1 for a valid port, and port 0 wins the first tie.
